inv_driver: RTL and testbench
=============================

# inv_driver

Initiator-side controller for the modular inverter (`inv`) in the BN254 pairing datapath. It accepts tagged operands on a valid/ready request port, issues a one-cycle start pulse with the operand to the inverter, and tracks the inverter's busy flag. When the inverter finishes, it captures the result and returns it, with the request tag and an error flag, on a valid/ready response port. Zero operands are answered locally without launching the inverter.

## Interface
- `WIDTH`, 268: operand/result width, equal to the `M_tilde12_t` width for BN254_d0.
- `TAG_W`, 4: request tag width.
- `TIMEOUT`, 4096: maximum cycles allowed in WAIT_BUSY plus RUN (timeout feature only).

- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `I_REQ_VALID`  in  1  request valid.
- `O_REQ_READY`  out  1  request ready.
- `I_REQ_DATA`  in  WIDTH  operand to invert.
- `I_REQ_TAG`  in  TAG_W  request tag.
- `O_RSP_VALID`  out  1  response valid.
- `I_RSP_READY`  in  1  response ready.
- `O_RSP_DATA`  out  WIDTH  inverse, or 0 on error.
- `O_RSP_TAG`  out  TAG_W  tag of the answered request.
- `O_RSP_ERR`  out  1  1 = zero operand or timeout.
- `O_INV_START`  out  1  one-cycle start pulse to the inverter's `I_START`.
- `O_INV_WDATA`  out  WIDTH  operand to the inverter's `I_WDATA`.
- `I_INV_BUSY`  in  1  inverter's `O_BUSY`.
- `I_INV_RDATA`  in  WIDTH  inverter result; valid once busy falls.
- `O_BUSY`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, ZERO, LAUNCH, WAIT_BUSY, RUN, RESP.
- `O_REQ_READY` = (state == IDLE) && !`I_INV_BUSY`.
- IDLE: on accept (valid && ready), latch `I_REQ_DATA` into the operand register and `I_REQ_TAG` into the tag register.
  - Operand == 0: go to ZERO.
  - Otherwise: go to LAUNCH.
- ZERO: load the response with data = 0, err = 1, then go to RESP. The inverter is not touched.
- LAUNCH: assert `O_INV_START` for exactly this cycle, then go to WAIT_BUSY.
- WAIT_BUSY: stay until `I_INV_BUSY` = 1, then go to RUN.
- RUN: stay while `I_INV_BUSY` = 1. On the first cycle with busy = 0:
  - capture `I_INV_RDATA` into the response data register;
  - set err = 0;
  - go to RESP.
- RESP: hold `O_RSP_VALID` = 1 with data, tag and err stable. On `I_RSP_READY`, go to IDLE.
- `O_INV_WDATA` always drives the operand register. It is stable from LAUNCH until the next accept.
- Requests are handled one at a time; there is no pipelining. A new request is not accepted in the same cycle as a response handshake.

## Timing
- Reset values: `O_REQ_READY` = 0 during reset, then follows its equation; all other outputs and internal registers are 0; state = IDLE.
- Nonzero request accepted at cycle t:
  - `O_INV_START` is high at t+1;
  - the inverter raises busy at t+2 or later;
  - if busy falls (is sampled low) at cycle b, `O_RSP_VALID` rises at b+1.
- Zero request accepted at t: `O_RSP_VALID` rises at t+2, with `O_INV_START` never asserted.
- The response is retired in the cycle `O_RSP_VALID` && `I_RSP_READY`. The earliest next accept is the following cycle.
- Reset in mid-operation: the FSM returns to IDLE, the pending response is dropped, and `O_INV_START` is low. Because ready is gated on `I_INV_BUSY`, no new start is issued until an abandoned inversion drains.
- `I_INV_BUSY` glitching high while in IDLE blocks only ready; it has no other effect.

## Configuration
- `INV_DRV_TIMEOUT_EN` defined:
  - a counter (width $clog2(TIMEOUT+1)) is cleared in LAUNCH and increments in WAIT_BUSY and RUN;
  - when it reaches `TIMEOUT`, the FSM loads data = 0, err = 1 and goes to RESP.
- Undefined: no counter is built, and WAIT_BUSY/RUN wait indefinitely. `O_RSP_ERR` is set only for zero operands.

## Test plan
- Operand 0x99ac9110…d8ad2a, tag 3; inverter model busy for 500 cycles -> one start pulse at t+1; response with the model's result, tag 3, err 0, exactly at fall+1.
- Operand 0, tag 7 -> no start pulse; response data 0, tag 7, err 1 at t+2.
- `I_RSP_READY` held low for 20 cycles in RESP -> valid, data and tag stay stable; `O_REQ_READY` stays 0; retire on the first ready cycle.
- Four back-to-back requests with tags 0..3 and ready always high -> four responses in order with matching tags; never two starts within one inversion.
- With `INV_DRV_TIMEOUT_EN` and `TIMEOUT` = 64, inverter model that never raises busy -> err 1, data 0 after 64 cycles in WAIT_BUSY.
- `rst` pulsed for 1 cycle in RUN while the model stays busy 100 more cycles -> `O_RSP_VALID` 0; `O_REQ_READY` stays 0 until busy falls, then 1.

Source files
------------

// File: rtl/inv_driver_if.sv
// -----------------------------------------------------------------------------
// inv_driver_if
// Bundles the request, response and inverter-side signals of inv_driver.
// Signal names keep the block's established I_/O_ names, seen from the driver.
//   slave  : the driver's view (takes requests, drives responses and start)
//   master : the environment's view (issues requests, models the inverter)
// Parameters: WIDTH (operand/result width), TAG_W (request tag width).
// -----------------------------------------------------------------------------
interface inv_driver_if #(
  parameter int WIDTH = 268,
  parameter int TAG_W = 4
);
  logic             I_REQ_VALID;
  logic             O_REQ_READY;
  logic [WIDTH-1:0] I_REQ_DATA;
  logic [TAG_W-1:0] I_REQ_TAG;
  logic             O_RSP_VALID;
  logic             I_RSP_READY;
  logic [WIDTH-1:0] O_RSP_DATA;
  logic [TAG_W-1:0] O_RSP_TAG;
  logic             O_RSP_ERR;
  logic             O_INV_START;
  logic [WIDTH-1:0] O_INV_WDATA;
  logic             I_INV_BUSY;
  logic [WIDTH-1:0] I_INV_RDATA;
  logic             O_BUSY;

  modport slave (
    input  I_REQ_VALID, I_REQ_DATA, I_REQ_TAG, I_RSP_READY, I_INV_BUSY, I_INV_RDATA,
    output O_REQ_READY, O_RSP_VALID, O_RSP_DATA, O_RSP_TAG, O_RSP_ERR,
           O_INV_START, O_INV_WDATA, O_BUSY
  );

  modport master (
    output I_REQ_VALID, I_REQ_DATA, I_REQ_TAG, I_RSP_READY, I_INV_BUSY, I_INV_RDATA,
    input  O_REQ_READY, O_RSP_VALID, O_RSP_DATA, O_RSP_TAG, O_RSP_ERR,
           O_INV_START, O_INV_WDATA, O_BUSY
  );
endinterface

// File: rtl/inv_driver.sv
// -----------------------------------------------------------------------------
// inv_driver
// Initiator-side controller for the BN254 modular inverter. Accepts one tagged
// operand at a time, pulses the inverter's start for one cycle, follows its
// busy flag and returns the captured result with the tag and an error flag.
// Zero operands are answered locally (data 0, err 1) without a launch.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - inv_driver_if.slave: request (valid/ready, data, tag), response
//          (valid/ready, data, tag, err), inverter start/wdata/busy/rdata,
//          and O_BUSY (high whenever the FSM is not idle)
//
// Optional feature: define INV_DRV_TIMEOUT_EN to build a watchdog counter that
// aborts an inversion with err = 1 once TIMEOUT cycles pass in WAIT_BUSY/RUN.
// -----------------------------------------------------------------------------
module inv_driver #(
  parameter int WIDTH   = 268,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  inv_driver_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ZERO      = 3'd1,
    ST_LAUNCH    = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_RUN       = 3'd4,
    ST_RESP      = 3'd5
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] operand_r;
  logic [TAG_W-1:0] tag_r;
  logic [WIDTH-1:0] rsp_data_r;
  logic             rsp_err_r;
  logic             start_r;
  logic             rsp_valid_r;
  logic             busy_r;
  logic             req_ready_s;
  logic             accept_s;
  logic             rsp_load_s;
  logic [WIDTH-1:0] rsp_data_s;
  logic             rsp_err_s;
  logic             timeout_s;

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("inv_driver: TIMEOUT must be at least 1");
  end

  // Ready is held low while in reset and while an abandoned inversion drains.
  assign req_ready_s = (state_r == ST_IDLE) && !bus.I_INV_BUSY && !rst;
  assign accept_s    = bus.I_REQ_VALID && req_ready_s;

`ifdef INV_DRV_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] tmo_cnt_r;

  assign timeout_s = (tmo_cnt_r == CNT_W'(TIMEOUT));

  // Watchdog: cleared at launch, counts every cycle spent waiting on the inverter.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_LAUNCH) begin
      tmo_cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == ST_WAIT_BUSY) || (state_r == ST_RUN)) begin
      tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state and response-load decode.
  always_comb begin
    state_next_s = state_r;
    rsp_load_s   = 1'b0;
    rsp_data_s   = {WIDTH{1'b0}};
    rsp_err_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (bus.I_REQ_DATA == {WIDTH{1'b0}}) begin
            state_next_s = ST_ZERO;
          end else begin
            state_next_s = ST_LAUNCH;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ZERO: begin
        state_next_s = ST_RESP;
        rsp_load_s   = 1'b1;
        rsp_err_s    = 1'b1;
      end
      ST_LAUNCH: begin
        state_next_s = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (timeout_s) begin
          state_next_s = ST_RESP;
          rsp_load_s   = 1'b1;
          rsp_err_s    = 1'b1;
        end else if (bus.I_INV_BUSY) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_WAIT_BUSY;
        end
      end
      ST_RUN: begin
        // A finished result wins over a coincident timeout.
        if (!bus.I_INV_BUSY) begin
          state_next_s = ST_RESP;
          rsp_load_s   = 1'b1;
          rsp_data_s   = bus.I_INV_RDATA;
          rsp_err_s    = 1'b0;
        end else if (timeout_s) begin
          state_next_s = ST_RESP;
          rsp_load_s   = 1'b1;
          rsp_err_s    = 1'b1;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_RESP: begin
        if (bus.I_RSP_READY) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register plus output flags registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      start_r     <= 1'b0;
      rsp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      start_r     <= (state_next_s == ST_LAUNCH);
      rsp_valid_r <= (state_next_s == ST_RESP);
      busy_r      <= (state_next_s != ST_IDLE);
    end
  end

  // Operand/tag capture on accept and response capture on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      operand_r  <= {WIDTH{1'b0}};
      tag_r      <= {TAG_W{1'b0}};
      rsp_data_r <= {WIDTH{1'b0}};
      rsp_err_r  <= 1'b0;
    end else begin
      if (accept_s) begin
        operand_r <= bus.I_REQ_DATA;
        tag_r     <= bus.I_REQ_TAG;
      end
      if (rsp_load_s) begin
        rsp_data_r <= rsp_data_s;
        rsp_err_r  <= rsp_err_s;
      end
    end
  end

  assign bus.O_REQ_READY = req_ready_s;
  assign bus.O_RSP_VALID = rsp_valid_r;
  assign bus.O_RSP_DATA  = rsp_data_r;
  assign bus.O_RSP_TAG   = tag_r;
  assign bus.O_RSP_ERR   = rsp_err_r;
  assign bus.O_INV_START = start_r;
  assign bus.O_INV_WDATA = operand_r;
  assign bus.O_BUSY      = busy_r;

endmodule

// File: tb/tb_inv_driver.sv
// -----------------------------------------------------------------------------
// tb_inv_driver
// Scoreboard bench for inv_driver: stimulus pushes expected responses into a
// queue, an inverter model serves launches, and a monitor pops and compares
// whenever the driver presents a response.
// -----------------------------------------------------------------------------
module tb_inv_driver;
  localparam int WIDTH   = 268;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 64;

  typedef logic [WIDTH-1:0] word_t;
  typedef struct { word_t rdata; int len; int acc; } job_t;
  typedef struct { word_t data; logic [TAG_W-1:0] tag; logic err; int kind; int rise; } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inv_driver_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus();

  inv_driver #(.WIDTH(WIDTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   fall_cyc = -100;
  int   n_starts = 0;
  int   n_dbl    = 0;
  bit   model_active = 1'b0;
  bit   mon_have = 1'b0;
  job_t model_q[$];
  rsp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (model_active && (bus.O_INV_START === 1'b1)) n_dbl <= n_dbl + 1;
  end

  task automatic chk(input string name, input word_t act, input word_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic fail_bound(input string name);
    n_checks++;
    $display("FAIL %s: wait bound expired before the expected event", name);
  endtask

  // Inverter model: on a start pulse, raise busy the next cycle for len cycles,
  // then drop busy with the queued result. len <= 0 means never raise busy.
  initial begin : inv_model
    job_t j;
    bus.I_INV_BUSY  = 1'b0;
    bus.I_INV_RDATA = '0;
    forever begin
      @(negedge clk);
      if (bus.O_INV_START === 1'b1) begin
        n_starts++;
        if (model_q.size() == 0) begin
          chk("start_without_job", word_t'(model_q.size()), word_t'(1));
        end else begin
          j = model_q.pop_front();
          chk("start_cycle", word_t'(cyc), word_t'(j.acc + 1));
          if (j.len > 0) begin
            @(posedge clk);
            #1;
            bus.I_INV_BUSY = 1'b1;
            model_active   = 1'b1;
            repeat (j.len) @(posedge clk);
            #1;
            bus.I_INV_RDATA = j.rdata;
            bus.I_INV_BUSY  = 1'b0;
            model_active    = 1'b0;
            fall_cyc        = cyc;
          end
        end
      end
    end
  end

  // Response monitor: pops the expected entry when a response first appears
  // and compares it every cycle until the handshake retires it.
  initial begin : rsp_mon
    rsp_t cur;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_have = 1'b0;
      end else if (bus.O_RSP_VALID === 1'b1) begin
        if (!mon_have) begin
          if (exp_q.size() == 0) begin
            chk("rsp_without_request", word_t'(exp_q.size()), word_t'(1));
          end else begin
            cur = exp_q.pop_front();
            mon_have = 1'b1;
            if (cur.kind == 0) chk("rsp_rise_cycle", word_t'(cyc), word_t'(cur.rise));
            else if (cur.kind == 1) chk("rsp_after_fall", word_t'(cyc), word_t'(fall_cyc + 1));
          end
        end
        if (mon_have) begin
          chk("rsp_data", bus.O_RSP_DATA, cur.data);
          chk("rsp_tag", word_t'(bus.O_RSP_TAG), word_t'(cur.tag));
          chk("rsp_err", word_t'(bus.O_RSP_ERR), word_t'(cur.err));
          chk("req_ready_in_resp", word_t'(bus.O_REQ_READY), word_t'(1'b0));
          if (bus.I_RSP_READY === 1'b1) mon_have = 1'b0;
        end
      end
    end
  end

  // Issue one request; push the expected response once it is accepted.
  task automatic send(input word_t data, input logic [TAG_W-1:0] tag,
                      input word_t rdata, input int len);
    int   n;
    rsp_t e;
    n = 0;
    @(posedge clk);
    #1;
    bus.I_REQ_VALID = 1'b1;
    bus.I_REQ_DATA  = data;
    bus.I_REQ_TAG   = tag;
    while (1) begin
      @(negedge clk);
      if (bus.O_REQ_READY === 1'b1) break;
      n++;
      if (n > 2000) break;
    end
    if (n > 2000) begin
      fail_bound("req_accept");
    end else begin
      e.tag = tag;
      if (data == '0) begin
        e.data = '0; e.err = 1'b1; e.kind = 0; e.rise = cyc + 2;
      end else if (len <= 0) begin
        e.data = '0; e.err = 1'b1; e.kind = 2; e.rise = 0;
        model_q.push_back('{rdata, len, cyc});
      end else begin
        e.data = rdata; e.err = 1'b0; e.kind = 1; e.rise = 0;
        model_q.push_back('{rdata, len, cyc});
      end
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.I_REQ_VALID = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !mon_have && bus.O_BUSY === 1'b0) break;
      n++;
      if (n > budget) break;
    end
    if (n > budget) fail_bound(name);
  endtask

  word_t op_a, res_a, op_c, res_c, op_r, res_r;
  word_t b2b_op[4];
  word_t b2b_res[4];
  int    b2b_len[4];
  int    n_exp_starts;

  initial begin : stim
    int n;
    op_a  = 268'h99ac9110_0123456789abcdef_fedcba9876543210_13579bdf02468ace_12345_d8ad2a;
    res_a = 268'h0a5f3c21_77770000_1111beef_cafe0042;
    op_c  = 268'h5;
    res_c = 268'h3333_4444_5555_6666;
    op_r  = 268'hdead_0001;
    res_r = 268'h0bad_f00d;
    b2b_op[0] = 268'h1;          b2b_res[0] = 268'h1;             b2b_len[0] = 3;
    b2b_op[1] = 268'h2;          b2b_res[1] = 268'h8000_0000_0001; b2b_len[1] = 1;
    b2b_op[2] = 268'hffff_ffff;  b2b_res[2] = 268'h0123_4567;     b2b_len[2] = 6;
    b2b_op[3] = 268'h7_0000_0000; b2b_res[3] = 268'hfedc_ba98;    b2b_len[3] = 2;
    n_exp_starts = 0;

    bus.I_REQ_VALID = 1'b0;
    bus.I_REQ_DATA  = '0;
    bus.I_REQ_TAG   = '0;
    bus.I_RSP_READY = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);

    // Reset state
    @(negedge clk);
    chk("reset_req_ready", word_t'(bus.O_REQ_READY), word_t'(1'b0));
    chk("reset_rsp_valid", word_t'(bus.O_RSP_VALID), word_t'(1'b0));
    chk("reset_rsp_data", bus.O_RSP_DATA, '0);
    chk("reset_rsp_tag", word_t'(bus.O_RSP_TAG), '0);
    chk("reset_rsp_err", word_t'(bus.O_RSP_ERR), '0);
    chk("reset_start", word_t'(bus.O_INV_START), '0);
    chk("reset_wdata", bus.O_INV_WDATA, '0);
    chk("reset_busy", word_t'(bus.O_BUSY), '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", word_t'(bus.O_REQ_READY), word_t'(1'b1));

    // Long inversion, tag 3
    send(op_a, 4'd3, res_a, 500);
    n_exp_starts++;
    chk("wdata_operand", bus.O_INV_WDATA, op_a);
    wait_drain("drain_long", 1000);
    chk("starts_after_long", word_t'(n_starts), word_t'(n_exp_starts));

    // Zero operand, tag 7: answered locally
    send('0, 4'd7, '0, 0);
    wait_drain("drain_zero", 50);
    chk("starts_after_zero", word_t'(n_starts), word_t'(n_exp_starts));

    // Response held for 20+ cycles with ready low
    bus.I_RSP_READY = 1'b0;
    send(op_c, 4'd5, res_c, 4);
    n_exp_starts++;
    n = 0;
    while (bus.O_RSP_VALID !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_bound("hold_wait_valid");
    repeat (20) @(negedge clk);
    @(posedge clk);
    #1;
    bus.I_RSP_READY = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("retired_valid", word_t'(bus.O_RSP_VALID), word_t'(1'b0));
    chk("retired_ready", word_t'(bus.O_REQ_READY), word_t'(1'b1));

    // Four back-to-back requests, tags 0..3
    for (int i = 0; i < 4; i++) begin
      send(b2b_op[i], 4'(i), b2b_res[i], b2b_len[i]);
      n_exp_starts++;
    end
    wait_drain("drain_b2b", 200);
    chk("starts_after_b2b", word_t'(n_starts), word_t'(n_exp_starts));

`ifdef INV_DRV_TIMEOUT_EN
    // Inverter never raises busy: watchdog answers with err
    send(268'h77, 4'd9, '0, 0);
    n_exp_starts++;
    wait_drain("drain_timeout", TIMEOUT + 100);
`endif

    // Reset pulsed while the inverter is running
    send(op_r, 4'd10, res_r, 120);
    n_exp_starts++;
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rst_mid_busy", word_t'(bus.O_BUSY), word_t'(1'b0));
    chk("rst_mid_start", word_t'(bus.O_INV_START), word_t'(1'b0));
    n = 0;
    while (1) begin
      if (!model_active) break;
      chk("drain_rsp_valid", word_t'(bus.O_RSP_VALID), word_t'(1'b0));
      chk("drain_req_ready", word_t'(bus.O_REQ_READY), word_t'(1'b0));
      @(negedge clk);
      n++;
      if (n > 500) break;
    end
    if (n > 500) fail_bound("abandoned_drain");
    chk("ready_after_drain", word_t'(bus.O_REQ_READY), word_t'(1'b1));
    chk("valid_after_drain", word_t'(bus.O_RSP_VALID), word_t'(1'b0));

    // Final bookkeeping
    repeat (5) @(negedge clk);
    chk("total_starts", word_t'(n_starts), word_t'(n_exp_starts));
    chk("double_starts", word_t'(n_dbl), '0);
    chk("jobs_left", word_t'(model_q.size()), '0);
    chk("rsp_left", word_t'(exp_q.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
